// File: rtl/lif_acc_pkg.sv
// rtl/lif_acc_pkg.sv - shared types and defaults for the LIF spike FIFO reader
package lif_acc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SCAN,
    S_EOS,
    S_DONE
  } state_t;

  localparam int DEF_NEURONS = 256;
  localparam int DEF_LANES   = 4;
  localparam int DEF_ADDR_W  = 8;
  localparam int EOS_ADDR    = 0;

endpackage

// File: rtl/lif_lane_priority_enc.sv
// rtl/lif_lane_priority_enc.sv - lowest-set-bit encoder over the spike lanes
module lif_lane_priority_enc #(
  parameter int LANES = 4,
  parameter int IDX_W = 2
) (
  input  logic [LANES-1:0] lanes,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scanning downward lets the lowest set lane win the final assignment.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lanes[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lif_spike_fifo_reader.sv
// rtl/lif_spike_fifo_reader.sv - drains one timestep of spike words from a FIFO
// into AER events followed by an end-of-step token.
module lif_spike_fifo_reader
  import lif_acc_pkg::*;
#(
  parameter int NEURONS = DEF_NEURONS,
  parameter int LANES   = DEF_LANES,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_o,
  input  logic [LANES-1:0]  fifo_rdata_bi,
  output logic              aer_valid_o,
  input  logic              aer_ready_i,
  output logic [ADDR_W-1:0] aer_addr_bo,
  output logic              aer_eos_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int WORDS = NEURONS / LANES;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] LANES_A   = ADDR_W'(LANES);

  if (NEURONS > (1 << ADDR_W)) begin : g_bad_neurons
    $error("NEURONS exceeds the AER address space 2**ADDR_W");
  end
  if ((NEURONS % LANES) != 0) begin : g_bad_lanes
    $error("NEURONS must be a multiple of LANES");
  end

  state_t            state;
  logic [ADDR_W-1:0] word;
  logic [LANES-1:0]  lanes;
  logic [IDX_W-1:0]  idx;
  logic              any;

  lif_lane_priority_enc #(
    .LANES(LANES),
    .IDX_W(IDX_W)
  ) u_enc (
    .lanes(lanes),
    .idx  (idx),
    .any  (any)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      word  <= '0;
      lanes <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            word  <= '0;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (!fifo_empty_i) state <= S_WAIT;
        end
        S_WAIT: begin
          lanes <= fifo_rdata_bi;
          state <= S_SCAN;
        end
        S_SCAN: begin
          if (any) begin
            if (aer_ready_i) lanes <= lanes & ~(LANES'(1) << idx);
          end else if (word == LAST_WORD) begin
            state <= S_EOS;
          end else begin
            word  <= word + 1'b1;
            state <= S_REQ;
          end
        end
        S_EOS: begin
          if (aer_ready_i) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Event outputs decode purely from registered state, so they hold while stalled.
  assign fifo_rd_o   = (state == S_REQ) && !fifo_empty_i && !rst_i;
  assign aer_valid_o = ((state == S_SCAN) && any) || (state == S_EOS);
  assign aer_eos_o   = (state == S_EOS);
  assign aer_addr_bo = ((state == S_SCAN) && any) ? (word * LANES_A + ADDR_W'(idx))
                                                  : ADDR_W'(EOS_ADDR);
  assign busy_o      = (state != S_IDLE);
  assign done_o      = (state == S_DONE);

endmodule
